// File: rtl/fft_stream_wrap.sv
// Valid/ready vector stream <-> HLS FFT core adapter: per-lane ap_fifo flow control,
// output lane re-alignment into a vector FIFO, and per-frame ap_start sequencing.
//
// state | meaning
// IDLE  | no frame in flight
// START | core_start asserted, waiting for core_ready
// RUN   | frame in flight, waiting for core_done

module fft_stream_wrap #(
   parameter int NUM_LANES  = 4,
   parameter int IN_W       = 32,
   parameter int OUT_W      = 42,
   parameter int FRAME_LEN  = 256,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [NUM_LANES*IN_W-1:0]    s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [NUM_LANES*OUT_W-1:0]   m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_last,
   output logic                         core_start,
   input  logic                         core_ready,
   input  logic                         core_done,
   input  logic                         core_idle,
   output logic [NUM_LANES*IN_W-1:0]    core_in_dout,
   output logic [NUM_LANES-1:0]         core_in_empty_n,
   input  logic [NUM_LANES-1:0]         core_in_read,
   input  logic [NUM_LANES*OUT_W-1:0]   core_out_din,
   output logic [NUM_LANES-1:0]         core_out_full_n,
   input  logic [NUM_LANES-1:0]         core_out_write,
   output logic                         busy,
   output logic [15:0]                  frame_cnt,
   output logic                         err_frame
);

   localparam int IW = NUM_LANES * IN_W;
   localparam int OW = NUM_LANES * OUT_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        hold_q, hold_d;
   logic                 hold_v_q, hold_v_d;
   logic [NUM_LANES-1:0] consumed_q, consumed_d, rd_hit;
   logic                 all_read, accept;
   logic [OW-1:0]        asm_q, asm_d;
   logic [NUM_LANES-1:0] filled_q, filled_d, wr_hit;
   logic [OW:0]          mem_q [FIFO_DEPTH];
   logic [OW:0]          mem_d [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]          cnt_q, cnt_d;
   logic                 push, pop, fifo_full;
   logic [CW-1:0]        vec_cnt_q, vec_cnt_d;
   logic [15:0]          frame_cnt_q, frame_cnt_d;
   logic                 err_q, err_d;
   logic                 unused_idle;

   // core_idle carries no information the FSM needs
   assign unused_idle = core_idle;

   // Input side: one held vector, released lane by lane; refill in the same cycle as the last read
   always_comb begin
      core_in_empty_n = {NUM_LANES{hold_v_q}} & ~consumed_q;
      rd_hit          = core_in_read & core_in_empty_n;
      all_read        = &(consumed_q | rd_hit);
      s_ready         = ~rst & (~hold_v_q | all_read);
      accept          = s_valid & s_ready;
      hold_d          = accept ? s_data : hold_q;
      hold_v_d        = accept | (hold_v_q & ~all_read);
      consumed_d      = accept ? '0 : (consumed_q | rd_hit);
   end

   assign core_in_dout = hold_q;

   // Output side: lanes land independently in the assembly register, whole vector enters the FIFO
   always_comb begin
      core_out_full_n = ~filled_q;
      wr_hit          = core_out_write & ~filled_q;
      asm_d           = asm_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr_hit[i]) asm_d[i*OUT_W +: OUT_W] = core_out_din[i*OUT_W +: OUT_W];
      end
      m_valid   = (cnt_q != '0);
      pop       = m_valid & m_ready;
      fifo_full = (cnt_q == DEPTH);
      push      = (&filled_q) & (~fifo_full | pop);
      filled_d  = push ? '0 : (filled_q | wr_hit);
      vec_cnt_d = vec_cnt_q;
      if (push) vec_cnt_d = (vec_cnt_q == LAST_IDX) ? '0 : vec_cnt_q + 1'b1;
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {(vec_cnt_q == LAST_IDX), asm_q};
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      m_data = mem_q[rd_ptr_q][OW-1:0];
      m_last = m_valid & mem_q[rd_ptr_q][OW];
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      err_d       = err_q;
      core_start  = 1'b0;
      case (state_q)
         S_IDLE:  if (en) state_d = S_START;
         S_START: begin
            core_start = 1'b1;
            if (core_ready) state_d = S_RUN;
         end
         S_RUN: begin
            // post-push count, so a final push landing with core_done is not flagged
            if (core_done) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               err_d       = err_q | (vec_cnt_d != '0);
               state_d     = en ? S_START : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign frame_cnt = frame_cnt_q;
   assign err_frame = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_v_q    <= 1'b0;
         consumed_q  <= '0;
         asm_q       <= '0;
         filled_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         vec_cnt_q   <= '0;
         frame_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         consumed_q  <= consumed_d;
         asm_q       <= asm_d;
         filled_q    <= filled_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         vec_cnt_q   <= vec_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_fft_stream_wrap.sv
// Bench for fft_stream_wrap: behavioural FFT core model with per-lane read/write skew,
// scoreboard of expected output vectors, frame-level phase table plus corner sequences.

module tb_fft_stream_wrap;

   localparam int NL    = 4;
   localparam int IN_W  = 32;
   localparam int OUT_W = 42;
   localparam int FL    = 256;
   localparam int FD    = 16;
   localparam int IW    = NL * IN_W;
   localparam int OW    = NL * OUT_W;
   localparam int TMO   = 30000;

   logic            clk = 1'b0;
   logic            rst, en, s_valid, s_ready, m_valid, m_ready, m_last;
   logic            core_start, core_ready, core_done, core_idle, busy, err_frame;
   logic [IW-1:0]   s_data, core_in_dout;
   logic [OW-1:0]   m_data, core_out_din;
   logic [NL-1:0]   core_in_empty_n, core_in_read, core_out_full_n, core_out_write;
   logic [15:0]     frame_cnt;

   always #5 clk = ~clk;

   fft_stream_wrap #(
      .NUM_LANES(NL), .IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(FL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
      .core_idle(core_idle),
      .core_in_dout(core_in_dout), .core_in_empty_n(core_in_empty_n),
      .core_in_read(core_in_read),
      .core_out_din(core_out_din), .core_out_full_n(core_out_full_n),
      .core_out_write(core_out_write),
      .busy(busy), .frame_cnt(frame_cnt), .err_frame(err_frame)
   );

   typedef struct { logic [OW-1:0] d; logic last; } exp_t;
   typedef struct { int nf; int rd_mode; int wsk_mode; int bp_mode; int frame_n; int exp_last; int exp_err; } phase_t;

   exp_t   exp_q[$];
   phase_t tbl[5];

   int n_chk, n_bad;
   int cyc, hs_cnt, n_out, n_last, viol, src_left, in_idx;
   int rd_mode, wsk_mode, bp_mode, frame_n;
   bit stall, running, took;
   int done_cnt;
   int rd_frm[NL], wr_frm[NL], wr_tot[NL], lwp[NL], lrp[NL];
   logic [IN_W-1:0] lbuf [NL][1024];
   int              lts  [NL][1024];

   assign core_idle = ~running;

   function automatic logic [OUT_W-1:0] lane_x(input int i, input logic [IN_W-1:0] v);
      return {(OUT_W-IN_W)'(i + 1), v};
   endfunction

   function automatic logic [OW-1:0] xform(input logic [IW-1:0] v);
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < NL; i++) r[i*OUT_W +: OUT_W] = lane_x(i, v[i*IN_W +: IN_W]);
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   // Core model, source and sink all act on the falling edge
   initial begin : bg
      exp_t e;
      bit   all_w;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            core_in_read = '0; core_out_write = '0; core_out_din = '0;
            core_ready = 1'b0; core_done = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
            running = 1'b0; took = 1'b0; done_cnt = -1; src_left = 0; in_idx = 0;
            exp_q.delete();
            for (int i = 0; i < NL; i++) begin
               rd_frm[i] = 0; wr_frm[i] = 0; wr_tot[i] = 0; lwp[i] = 0; lrp[i] = 0;
            end
         end else begin
            m_ready = stall ? 1'b0 : ((bp_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (m_valid && m_ready) begin
               n_out++;
               if (m_last) n_last++;
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL sb_extra: got data=%h with no vector expected", m_data);
               end else begin
                  e = exp_q.pop_front();
                  if (m_data !== e.d || m_last !== e.last) begin
                     n_bad++;
                     $display("FAIL sb_data: got data=%h last=%b want data=%h last=%b",
                              m_data, m_last, e.d, e.last);
                  end
               end
            end
            for (int i = 0; i < NL; i++) begin
               core_out_write[i] = 1'b0;
               if (lrp[i] != lwp[i] && core_out_full_n[i] &&
                   cyc >= lts[i][lrp[i] % 1024] + 1 + ((wsk_mode != 0) ? i : 0)) begin
                  core_out_write[i] = 1'b1;
                  core_out_din[i*OUT_W +: OUT_W] = lane_x(i, lbuf[i][lrp[i] % 1024]);
                  lrp[i]++; wr_frm[i]++; wr_tot[i]++;
               end
            end
            for (int i = 0; i < NL; i++) begin
               core_in_read[i] = 1'b0;
               if (running && core_in_empty_n[i] && rd_frm[i] < frame_n &&
                   (rd_mode == 0 || (cyc % NL) == i)) begin
                  core_in_read[i] = 1'b1;
                  lbuf[i][lwp[i] % 1024] = core_in_dout[i*IN_W +: IN_W];
                  lts[i][lwp[i] % 1024]  = cyc;
                  lwp[i]++; rd_frm[i]++;
               end
            end
            core_ready = 1'b0;
            core_done  = 1'b0;
            if (!running) begin
               if (core_start) begin
                  core_ready = 1'b1; running = 1'b1; hs_cnt++; done_cnt = -1;
                  for (int i = 0; i < NL; i++) begin rd_frm[i] = 0; wr_frm[i] = 0; end
               end
            end else if (done_cnt < 0) begin
               all_w = 1'b1;
               for (int i = 0; i < NL; i++) if (wr_frm[i] != frame_n) all_w = 1'b0;
               if (all_w) done_cnt = 3;
            end else if (done_cnt == 0) begin
               core_done = 1'b1; running = 1'b0; done_cnt = -1;
            end else begin
               done_cnt--;
            end
            if (!s_valid || took) begin
               took = 1'b0;
               if (src_left > 0) begin
                  s_valid = 1'b1;
                  for (int i = 0; i < NL; i++) s_data[i*IN_W +: IN_W] = $urandom;
                  src_left--;
               end else begin
                  s_valid = 1'b0;
               end
            end
            #1;
            if (s_ready) begin
               for (int i = 0; i < NL; i++) if (core_in_empty_n[i] && !core_in_read[i]) viol++;
            end
            if (s_valid && s_ready) begin
               took   = 1'b1;
               e.d    = xform(s_data);
               e.last = ((in_idx % FL) == FL - 1);
               exp_q.push_back(e);
               in_idx++;
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_s_ready"},    int'(s_ready), 0);
      chk({tag, "_m_valid"},    int'(m_valid), 0);
      chk({tag, "_m_last"},     int'(m_last), 0);
      chk({tag, "_core_start"}, int'(core_start), 0);
      chk({tag, "_busy"},       int'(busy), 0);
      chk({tag, "_err_frame"},  int'(err_frame), 0);
      chk({tag, "_frame_cnt"},  int'(frame_cnt), 0);
      chk({tag, "_empty_n"},    int'(core_in_empty_n), 0);
      chk({tag, "_full_n"},     int'(core_out_full_n), (1 << NL) - 1);
   endtask

   task automatic wait_out(input string tag, input int target);
      int k;
      for (k = 0; k < TMO; k++) begin
         if (n_out >= target) break;
         step();
      end
      if (k >= TMO) chk({tag, "_out_timeout"}, n_out, target);
   endtask

   task automatic finish_phase(input string tag, input int nf, input int hs0, input int fc0,
                               input int nout0, input int nlast0, input int viol0,
                               input int nvec, input int exp_last, input int exp_err);
      int k;
      for (k = 0; k < TMO; k++) begin
         if (hs_cnt >= hs0 + nf) break;
         step();
      end
      if (k >= TMO) chk({tag, "_hs_timeout"}, hs_cnt - hs0, nf);
      en = 1'b0;
      for (k = 0; k < TMO; k++) begin
         if (!busy && exp_q.size() == 0 && src_left == 0 && !s_valid && !m_valid) break;
         step();
      end
      if (k >= TMO) chk({tag, "_idle_timeout"}, exp_q.size(), 0);
      chk({tag, "_frame_cnt"}, int'(frame_cnt), (fc0 + nf) % 65536);
      chk({tag, "_err_frame"}, int'(err_frame), exp_err);
      chk({tag, "_handshakes"}, hs_cnt - hs0, nf);
      chk({tag, "_vectors"}, n_out - nout0, nvec);
      chk({tag, "_m_last_cnt"}, n_last - nlast0, exp_last);
      chk({tag, "_early_ready"}, viol - viol0, 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin : main
      int fc0, hs0, nout0, nlast0, viol0;
      string tag;
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      core_ready = 1'b0; core_done = 1'b0; core_in_read = '0; core_out_write = '0; core_out_din = '0;
      stall = 1'b0; rd_mode = 0; wsk_mode = 0; bp_mode = 0; frame_n = FL;
      n_chk = 0; n_bad = 0; hs_cnt = 0; n_out = 0; n_last = 0; viol = 0; cyc = 0;
      // nf, rd_mode, wsk_mode, bp_mode, frame_n, exp_last, exp_err
      tbl[0] = '{1, 0, 0, 0, FL,     1, 0};
      tbl[1] = '{1, 1, 0, 0, FL,     1, 0};
      tbl[2] = '{1, 0, 1, 1, FL,     1, 0};
      tbl[3] = '{3, 0, 1, 0, FL,     3, 0};
      tbl[4] = '{1, 0, 0, 0, FL - 1, 0, 1};

      repeat (3) step();
      check_reset("init");
      rst = 1'b0;
      step(); step();

      for (int p = 0; p < 5; p++) begin
         tag = $sformatf("p%0d", p);
         rd_mode = tbl[p].rd_mode; wsk_mode = tbl[p].wsk_mode;
         bp_mode = tbl[p].bp_mode; frame_n = tbl[p].frame_n;
         fc0 = int'(frame_cnt); hs0 = hs_cnt; nout0 = n_out; nlast0 = n_last; viol0 = viol;
         src_left = tbl[p].nf * tbl[p].frame_n;
         en = 1'b1;
         finish_phase(tag, tbl[p].nf, hs0, fc0, nout0, nlast0, viol0,
                      tbl[p].nf * tbl[p].frame_n, tbl[p].exp_last, tbl[p].exp_err);
      end

      // Reset in the middle of a frame (err_frame is still set from the short frame)
      rd_mode = 0; wsk_mode = 0; bp_mode = 0; frame_n = FL;
      nout0 = n_out; src_left = FL; en = 1'b1;
      wait_out("mid", nout0 + 50);
      rst = 1'b1; en = 1'b0;
      step();
      check_reset("mid");
      step();
      rst = 1'b0;
      step(); step();

      // Downstream stall: FIFO fills, lanes held off, order intact after release
      fc0 = int'(frame_cnt); hs0 = hs_cnt; nout0 = n_out; nlast0 = n_last; viol0 = viol;
      src_left = FL; en = 1'b1;
      wait_out("bp", nout0 + 60);
      stall = 1'b1;
      repeat (40) step();
      chk("bp_full_n", int'(core_out_full_n), 0);
      chk("bp_m_valid", int'(m_valid), 1);
      chk("bp_queued", wr_tot[0] - (n_out - nout0), FD + 1);
      stall = 1'b0;
      finish_phase("bp", 1, hs0, fc0, nout0, nlast0, viol0, FL, 1, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
